eth_mfb_to_avst_realigner: RTL and testbench
============================================

# eth_mfb_to_avst_realigner

TX-side counterpart of the RX AVST shakedown adapter in the MAC lite. Accepts a single-region MFB stream in which packets may start on any block boundary. Repacks it into an Avalon-ST stream where every packet starts at byte 0 of a word and each word carries bytes of at most one packet. Sits between the TX MAC lite buffer and the Ethernet hard-IP AVST TX port.

## Interface
- DATA_WIDTH, 512, word width in bits; W = DATA_WIDTH/8 bytes per word.
- REGION_SIZE, 8, blocks per word; block = W/REGION_SIZE bytes (BB).
- CLK  in  1  clock, all logic on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- IN_MFB_DATA  in  DATA_WIDTH  input word; byte 0 = bits 7:0.
- IN_MFB_SOF  in  1  packet starts in this word.
- IN_MFB_SOF_POS  in  log2(REGION_SIZE)  block index of first packet byte.
- IN_MFB_EOF  in  1  packet ends in this word.
- IN_MFB_EOF_POS  in  log2(W)  byte index of last packet byte.
- IN_MFB_SRC_RDY  in  1  input word valid.
- IN_MFB_DST_RDY  out  1  block accepts input word.
- OUT_AVST_DATA  out  DATA_WIDTH  output word, packet byte k*W+b at byte b.
- OUT_AVST_SOP  out  1  first word of packet.
- OUT_AVST_EOP  out  1  last word of packet.
- OUT_AVST_EMPTY  out  log2(W)  unused bytes in EOP word (0 when EOP=0).
- OUT_AVST_VALID  out  1  output word valid.
- OUT_AVST_READY  in  1  sink accepts (ready latency 0).

## Operation
- Input transfer: IN_MFB_SRC_RDY & IN_MFB_DST_RDY. Output transfer: OUT_AVST_VALID & OUT_AVST_READY.
- Per input word, packet segments are taken in byte order. If EOF and SOF are both set and SOF_POS*BB > EOF_POS, the word holds the tail of packet A (bytes 0..EOF_POS) followed by the head of packet B. Otherwise a SOF word holds only a head segment, or a single whole packet when EOF is also set.
- Segment start = SOF_POS*BB for a head, else 0. Segment end = EOF_POS for a tail, else W-1. N = end-start+1.
- Residue register RES holds R bytes (0..W-1) of the open packet, plus flag RES_SOP, which means no word of this packet has been emitted yet. R width is log2(W). R+N is computed on log2(W)+1 bits.
- Adding a segment:
  - R+N < W and no EOF: append, R := R+N.
  - R+N >= W: emit a full word (RES bytes followed by the first W-R segment bytes); R := R+N-W.
  - EOF: after any full word, emit the remaining bytes with EOP=1 and EMPTY = W-remaining, but only if remaining > 0. Then R := 0.
- An EOF word can produce two output words: a full word plus an EOP tail, or an A tail followed by B's head going into RES. The block then takes 2 cycles for that input word. IN_MFB_DST_RDY is low on the second cycle, and the input word is consumed only after its last output is loaded.
- SOP=1 on the first emitted word of each packet.
- Unused output bytes (above W-EMPTY) are driven 0.
- States:
  - IDLE: no open packet, R=0.
  - PKT: packet open.
  - SPLIT: second output of the current input word pending.
- Transitions:
  - IDLE->PKT on a SOF without EOF.
  - PKT->IDLE on an EOF with no new SOF.
  - PKT->SPLIT / IDLE->SPLIT when two outputs are needed.
  - SPLIT->PKT or SPLIT->IDLE once the second output is loaded.
- Words without SOF arriving in IDLE are accepted and dropped (no output).
- A SOF while PKT is open without a preceding EOF is a protocol error. The open packet is closed with an EOP word of R bytes and the new packet is started.

## Timing
- Reset values: OUT_AVST_VALID=0, SOP=0, EOP=0, EMPTY=0, DATA=0, IN_MFB_DST_RDY=0, state=IDLE, R=0. IN_MFB_DST_RDY rises in the first cycle after reset release.
- Output is registered. A word becomes visible one cycle after the input transfer that completes it.
- Whole aligned packet: output 1 cycle after input.
- Output register: it loads when empty or being read in the same cycle. It holds DATA/SOP/EOP/EMPTY stable while VALID=1 and READY=0.
- IN_MFB_DST_RDY = (state != SPLIT) & (!OUT_AVST_VALID | OUT_AVST_READY). It is combinational from OUT_AVST_READY.
- Full throughput (one word per cycle) when no split occurs and READY stays high.
- Reset asserted mid-packet: residue and output register are discarded immediately. Continuation words after release are dropped until the next SOF.

## Test plan
- W=64, BB=8 throughout.
- Aligned 64 B packet, SOF_POS=0, EOF_POS=63 -> one word next cycle, SOP=1, EOP=1, EMPTY=0.
- 100 B packet: SOF_POS=2 (48 B), then EOF_POS=51 (52 B) -> first word 64 B with SOP after the second input; then 36 B with EOP, EMPTY=28; DST_RDY stays high.
- 96 B packet: SOF_POS=4 (32 B), then EOF_POS=63 -> two outputs (64 B SOP, then 32 B EOP, EMPTY=32); DST_RDY low for exactly 1 cycle.
- Word with EOF_POS=23 closing A (R=8) and SOF_POS=4 opening B -> A's EOP word of 32 B (EMPTY=32); B's 32 B held in RES; next B word produces B's SOP word.
- READY low for 5 cycles mid-packet with SRC_RDY constant -> output word unchanged, DST_RDY low, byte stream identical to the no-backpressure run.
- RESET pulse after the head of a 200 B packet; 2 continuation words follow, then a fresh 64 B aligned packet -> no output for the continuation words; the fresh packet is output intact with SOP=1, EOP=1.

Source files
------------

// File: rtl/eth_mfb_to_avst_realigner.sv
// Repacks a single-region MFB stream into Avalon-ST words where every packet
// starts at byte 0 and no word carries bytes of two packets.
module eth_mfb_to_avst_realigner #(
    parameter int DATA_WIDTH  = 512,
    parameter int REGION_SIZE = 8
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic [DATA_WIDTH-1:0]             IN_MFB_DATA,
    input  logic                              IN_MFB_SOF,
    input  logic [$clog2(REGION_SIZE)-1:0]    IN_MFB_SOF_POS,
    input  logic                              IN_MFB_EOF,
    input  logic [$clog2(DATA_WIDTH/8)-1:0]   IN_MFB_EOF_POS,
    input  logic                              IN_MFB_SRC_RDY,
    output logic                              IN_MFB_DST_RDY,
    output logic [DATA_WIDTH-1:0]             OUT_AVST_DATA,
    output logic                              OUT_AVST_SOP,
    output logic                              OUT_AVST_EOP,
    output logic [$clog2(DATA_WIDTH/8)-1:0]   OUT_AVST_EMPTY,
    output logic                              OUT_AVST_VALID,
    input  logic                              OUT_AVST_READY
);
    localparam int W  = DATA_WIDTH / 8;
    localparam int BB = W / REGION_SIZE;
    localparam int SW = $clog2(REGION_SIZE);
    localparam int EW = $clog2(W);

    typedef logic [EW:0] cnt_t;
    typedef enum logic [1:0] {IDLE, PKT, SPLIT} st_t;

    st_t                 st_q, st_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic [EW-1:0]       r_q, r_d;
    logic                rsop_q, rsop_d;
    logic                pend_q, pend_d;
    logic                en_q;
    logic [DATA_WIDTH-1:0] h_data_q;
    logic                h_sof_q, h_eof_q;
    logic [SW-1:0]       h_sofp_q;
    logic [EW-1:0]       h_eofp_q;
    logic                ov_q, osop_q, oeop_q;
    logic [DATA_WIDTH-1:0] od_q;
    logic [EW-1:0]       oemp_q;

    logic                split, out_free, go, fire;
    logic [DATA_WIDTH-1:0] w_data, seg, word, lo_data, bh_data;
    logic                w_sof, w_eof, th, fresh, full, a_sop;
    logic [SW-1:0]       w_sofp;
    logic [EW-1:0]       w_eofp;
    cnt_t                sof_start, seg_st, seg_end, seg_n, a_r, sum, lo_n;
    cnt_t                bh_n, emp_sum, close_emp;
    logic [DATA_WIDTH-1:0] a_res;

    logic                emit, e_sop, e_eop, do_e;
    logic [DATA_WIDTH-1:0] e_data;
    logic [EW-1:0]       e_empty;

    function automatic logic [DATA_WIDTH-1:0] seg_f(
        input logic [DATA_WIDTH-1:0] d,
        input cnt_t                  st,
        input cnt_t                  n
    );
        logic [DATA_WIDTH-1:0] s;
        s = d >> {st, 3'b000};
        for (int b = 0; b < W; b++)
            if (cnt_t'(b) >= n) s[b*8 +: 8] = '0;
        return s;
    endfunction

    assign split    = (st_q == SPLIT);
    assign out_free = !ov_q || OUT_AVST_READY;
    assign IN_MFB_DST_RDY = en_q && !split && out_free;
    assign fire     = IN_MFB_SRC_RDY && IN_MFB_DST_RDY;
    assign go       = split ? out_free : fire;

    // The second pass of a split word works from the latched copy.
    assign w_data = split ? h_data_q : IN_MFB_DATA;
    assign w_sof  = split ? h_sof_q  : IN_MFB_SOF;
    assign w_eof  = split ? h_eof_q  : IN_MFB_EOF;
    assign w_sofp = split ? h_sofp_q : IN_MFB_SOF_POS;
    assign w_eofp = split ? h_eofp_q : IN_MFB_EOF_POS;

    assign sof_start = cnt_t'(w_sofp) * cnt_t'(BB);
    assign th      = w_sof && w_eof && (sof_start > cnt_t'(w_eofp));
    assign fresh   = w_sof && !th;
    assign seg_st  = fresh ? sof_start : '0;
    assign seg_end = w_eof ? cnt_t'(w_eofp) : cnt_t'(W - 1);
    assign seg_n   = seg_end - seg_st + cnt_t'(1);
    assign seg     = seg_f(w_data, seg_st, seg_n);

    assign a_r     = fresh ? '0 : cnt_t'(r_q);
    assign a_res   = fresh ? '0 : res_q;
    assign a_sop   = fresh || rsop_q;
    assign sum     = a_r + seg_n;
    assign full    = sum >= cnt_t'(W);
    assign lo_n    = sum - cnt_t'(W);
    assign word    = a_res | (seg << {a_r, 3'b000});
    assign lo_data = seg >> {cnt_t'(W) - a_r, 3'b000};
    assign emp_sum = cnt_t'(W) - sum;
    assign close_emp = cnt_t'(W) - cnt_t'(r_q);

    assign bh_n    = cnt_t'(W) - sof_start;
    assign bh_data = seg_f(w_data, sof_start, bh_n);

    always_comb begin
        st_d = st_q;  res_d = res_q;  r_d = r_q;
        rsop_d = rsop_q;  pend_d = pend_q;
        emit = 1'b0;  e_data = '0;  e_sop = 1'b0;
        e_eop = 1'b0;  e_empty = '0;  do_e = 1'b0;
        if (go) begin
            unique case (st_q)
                IDLE: begin
                    if (th) begin
                        res_d = bh_data;  r_d = bh_n[EW-1:0];
                        rsop_d = 1'b1;  st_d = PKT;
                    end else if (w_sof) begin
                        do_e = 1'b1;
                    end
                end
                PKT: begin
                    if (fresh) begin
                        // New SOF with the previous packet still open: close it.
                        if (r_q != '0) begin
                            emit = 1'b1;  e_data = res_q;  e_sop = rsop_q;
                            e_eop = 1'b1;  e_empty = close_emp[EW-1:0];
                        end
                        res_d = '0;  r_d = '0;  pend_d = 1'b0;  st_d = SPLIT;
                    end else begin
                        do_e = 1'b1;
                    end
                end
                SPLIT: begin
                    pend_d = 1'b0;
                    if (pend_q) begin
                        emit = 1'b1;  e_data = res_q;  e_sop = rsop_q;
                        e_eop = 1'b1;  e_empty = close_emp[EW-1:0];
                    end
                    res_d = '0;  r_d = '0;  st_d = IDLE;
                    if (th) begin
                        res_d = bh_data;  r_d = bh_n[EW-1:0];
                        rsop_d = 1'b1;  st_d = PKT;
                    end else if (w_sof) begin
                        do_e = 1'b1;
                    end
                end
                default: st_d = IDLE;
            endcase
            if (do_e) begin
                if (full) begin
                    emit = 1'b1;  e_data = word;  e_sop = a_sop;
                    e_eop = w_eof && (lo_n == '0);  rsop_d = 1'b0;
                    if (w_eof && lo_n != '0) begin
                        pend_d = 1'b1;  res_d = lo_data;
                        r_d = lo_n[EW-1:0];  st_d = SPLIT;
                    end else if (w_eof) begin
                        res_d = '0;  r_d = '0;  st_d = IDLE;
                    end else begin
                        res_d = lo_data;  r_d = lo_n[EW-1:0];  st_d = PKT;
                    end
                end else if (w_eof) begin
                    emit = 1'b1;  e_data = word;  e_sop = a_sop;
                    e_eop = 1'b1;  e_empty = emp_sum[EW-1:0];
                    rsop_d = 1'b0;  res_d = '0;  r_d = '0;  st_d = IDLE;
                end else begin
                    res_d = word;  r_d = sum[EW-1:0];
                    rsop_d = a_sop;  st_d = PKT;
                end
                if (th) st_d = SPLIT;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            st_q <= IDLE;  res_q <= '0;  r_q <= '0;
            rsop_q <= 1'b0;  pend_q <= 1'b0;  en_q <= 1'b0;
            h_data_q <= '0;  h_sof_q <= 1'b0;  h_eof_q <= 1'b0;
            h_sofp_q <= '0;  h_eofp_q <= '0;
            ov_q <= 1'b0;  od_q <= '0;  osop_q <= 1'b0;
            oeop_q <= 1'b0;  oemp_q <= '0;
        end else begin
            en_q   <= 1'b1;
            st_q   <= st_d;
            res_q  <= res_d;
            r_q    <= r_d;
            rsop_q <= rsop_d;
            pend_q <= pend_d;
            if (fire) begin
                h_data_q <= IN_MFB_DATA;
                h_sof_q  <= IN_MFB_SOF;
                h_eof_q  <= IN_MFB_EOF;
                h_sofp_q <= IN_MFB_SOF_POS;
                h_eofp_q <= IN_MFB_EOF_POS;
            end
            if (out_free) begin
                ov_q   <= emit;
                od_q   <= e_data;
                osop_q <= e_sop;
                oeop_q <= e_eop;
                oemp_q <= e_empty;
            end
        end
    end

    assign OUT_AVST_VALID = ov_q;
    assign OUT_AVST_DATA  = od_q;
    assign OUT_AVST_SOP   = osop_q;
    assign OUT_AVST_EOP   = oeop_q;
    assign OUT_AVST_EMPTY = oemp_q;
endmodule

// File: tb/tb_eth_mfb_to_avst_realigner.sv
// Directed bench for the MFB to AVST realigner: packets are built from a byte
// pattern and every output word is compared against the expected packet layout.
module tb_eth_mfb_to_avst_realigner;
    localparam int W = 64;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic [511:0] IN_MFB_DATA;
    logic         IN_MFB_SOF;
    logic [2:0]   IN_MFB_SOF_POS;
    logic         IN_MFB_EOF;
    logic [5:0]   IN_MFB_EOF_POS;
    logic         IN_MFB_SRC_RDY;
    logic         IN_MFB_DST_RDY;
    logic [511:0] OUT_AVST_DATA;
    logic         OUT_AVST_SOP;
    logic         OUT_AVST_EOP;
    logic [5:0]   OUT_AVST_EMPTY;
    logic         OUT_AVST_VALID;
    logic         OUT_AVST_READY;

    typedef struct {
        logic [511:0] d;
        logic         sop;
        logic         eop;
        logic [5:0]   emp;
    } ow_t;

    ow_t got_q[$];
    ow_t exp_q[$];
    int  n_run = 0;
    int  n_fail = 0;

    eth_mfb_to_avst_realigner dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .IN_MFB_DATA    (IN_MFB_DATA),
        .IN_MFB_SOF     (IN_MFB_SOF),
        .IN_MFB_SOF_POS (IN_MFB_SOF_POS),
        .IN_MFB_EOF     (IN_MFB_EOF),
        .IN_MFB_EOF_POS (IN_MFB_EOF_POS),
        .IN_MFB_SRC_RDY (IN_MFB_SRC_RDY),
        .IN_MFB_DST_RDY (IN_MFB_DST_RDY),
        .OUT_AVST_DATA  (OUT_AVST_DATA),
        .OUT_AVST_SOP   (OUT_AVST_SOP),
        .OUT_AVST_EOP   (OUT_AVST_EOP),
        .OUT_AVST_EMPTY (OUT_AVST_EMPTY),
        .OUT_AVST_VALID (OUT_AVST_VALID),
        .OUT_AVST_READY (OUT_AVST_READY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pb(input int id, input int k);
        return 8'((id * 53 + k * 7 + 3) & 255);
    endfunction

    function automatic logic [511:0] place(input logic [511:0] w, input int id,
                                           input int off, input int pos,
                                           input int cnt);
        for (int i = 0; i < cnt; i++) w[(pos + i) * 8 +: 8] = pb(id, off + i);
        return w;
    endfunction

    task automatic exp_pkt(input int id, input int len);
        int  nw;
        ow_t o;
        nw = (len + W - 1) / W;
        for (int j = 0; j < nw; j++) begin
            o.d = '0;
            for (int b = 0; b < W; b++)
                if (j * W + b < len) o.d[b*8 +: 8] = pb(id, j * W + b);
            o.sop = (j == 0);
            o.eop = (j == nw - 1);
            o.emp = (j == nw - 1) ? 6'(nw * W - len) : 6'd0;
            exp_q.push_back(o);
        end
    endtask

    always @(negedge CLK) begin
        if (!RESET && OUT_AVST_VALID && OUT_AVST_READY)
            got_q.push_back('{OUT_AVST_DATA, OUT_AVST_SOP,
                              OUT_AVST_EOP, OUT_AVST_EMPTY});
    end

    task automatic send(input logic [511:0] d, input logic sof, input int sp,
                        input logic eof, input int ep);
        int n;
        n = 0;
        IN_MFB_DATA    = d;
        IN_MFB_SOF     = sof;
        IN_MFB_SOF_POS = 3'(sp);
        IN_MFB_EOF     = eof;
        IN_MFB_EOF_POS = 6'(ep);
        IN_MFB_SRC_RDY = 1'b1;
        @(negedge CLK);
        while (!IN_MFB_DST_RDY && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (!IN_MFB_DST_RDY) chk("send_timeout", IN_MFB_DST_RDY, 1);
        @(posedge CLK);
        #1;
        IN_MFB_SRC_RDY = 1'b0;
    endtask

    task automatic idle(input int c);
        repeat (c) @(posedge CLK);
        #1;
    endtask

    task automatic check_out(input string tag);
        int n;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        chk({tag, "_count"}, 512'(got_q.size()), 512'(exp_q.size()));
        for (int i = 0; i < n; i++) begin
            chk({tag, "_data"}, got_q[i].d, exp_q[i].d);
            chk({tag, "_sop"}, got_q[i].sop, exp_q[i].sop);
            chk({tag, "_eop"}, got_q[i].eop, exp_q[i].eop);
            chk({tag, "_empty"}, got_q[i].emp, exp_q[i].emp);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [511:0] w0;
        IN_MFB_DATA = '0;  IN_MFB_SOF = 0;  IN_MFB_SOF_POS = '0;
        IN_MFB_EOF = 0;  IN_MFB_EOF_POS = '0;  IN_MFB_SRC_RDY = 0;
        OUT_AVST_READY = 1'b1;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_valid", OUT_AVST_VALID, 0);
        chk("rst_dst_rdy", IN_MFB_DST_RDY, 0);
        chk("rst_data", OUT_AVST_DATA, 0);
        chk("rst_sop", OUT_AVST_SOP, 0);
        chk("rst_eop", OUT_AVST_EOP, 0);
        chk("rst_empty", OUT_AVST_EMPTY, 0);
        RESET = 1'b0;
        @(negedge CLK);
        chk("rst_rel_dst_rdy", IN_MFB_DST_RDY, 1);
        @(posedge CLK);
        #1;

        // aligned 64 B packet, output one cycle later
        exp_pkt(1, 64);
        send(place('0, 1, 0, 0, 64), 1, 0, 1, 63);
        @(negedge CLK);
        chk("t1_lat_valid", OUT_AVST_VALID, 1);
        chk("t1_lat_sop", OUT_AVST_SOP, 1);
        chk("t1_lat_eop", OUT_AVST_EOP, 1);
        chk("t1_lat_empty", OUT_AVST_EMPTY, 0);
        idle(3);
        check_out("t1");

        // 100 B: 48 B head at block 2, 52 B tail
        exp_pkt(2, 100);
        send(place('0, 2, 0, 16, 48), 1, 2, 0, 0);
        chk("t2_dst_rdy", IN_MFB_DST_RDY, 1);
        chk("t2_no_out", OUT_AVST_VALID, 0);
        send(place('0, 2, 48, 0, 52), 0, 0, 1, 51);
        idle(4);
        check_out("t2");

        // 96 B: 32 B head then full 64 B tail, split for one cycle
        exp_pkt(3, 96);
        send(place('0, 3, 0, 32, 32), 1, 4, 0, 0);
        send(place('0, 3, 32, 0, 64), 0, 0, 1, 63);
        @(negedge CLK);
        chk("t3_rdy_low", IN_MFB_DST_RDY, 0);
        @(negedge CLK);
        chk("t3_rdy_high", IN_MFB_DST_RDY, 1);
        idle(3);
        check_out("t3");

        // A (8 + 24 B) tail and B head share one word
        exp_pkt(4, 32);
        exp_pkt(5, 96);
        send(place('0, 4, 0, 56, 8), 1, 7, 0, 0);
        send(place(place('0, 4, 8, 0, 24), 5, 0, 32, 32), 1, 4, 1, 23);
        send(place('0, 5, 32, 0, 64), 0, 0, 1, 63);
        idle(4);
        check_out("t4");

        // 200 B with 5 cycles of sink backpressure mid-packet
        exp_pkt(6, 200);
        w0 = exp_q[0].d;
        fork
            begin
                send(place('0, 6, 0, 24, 40), 1, 3, 0, 0);
                send(place('0, 6, 40, 0, 64), 0, 0, 0, 0);
                send(place('0, 6, 104, 0, 64), 0, 0, 0, 0);
                send(place('0, 6, 168, 0, 32), 0, 0, 1, 31);
            end
            begin
                @(posedge CLK);
                @(posedge CLK);
                #1;
                OUT_AVST_READY = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge CLK);
                    chk("t5_hold_valid", OUT_AVST_VALID, 1);
                    chk("t5_hold_data", OUT_AVST_DATA, w0);
                    chk("t5_hold_dst_rdy", IN_MFB_DST_RDY, 0);
                end
                @(posedge CLK);
                #1;
                OUT_AVST_READY = 1'b1;
            end
        join
        idle(4);
        check_out("t5");

        // reset mid-packet, continuation dropped, fresh packet intact
        send(place('0, 7, 0, 32, 32), 1, 4, 0, 0);
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        chk("t6_rst_valid", OUT_AVST_VALID, 0);
        chk("t6_rst_dst_rdy", IN_MFB_DST_RDY, 0);
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        send(place('0, 7, 32, 0, 64), 0, 0, 0, 0);
        send(place('0, 7, 96, 0, 64), 0, 0, 0, 0);
        idle(2);
        chk("t6_dropped", 512'(got_q.size()), 0);
        exp_pkt(8, 64);
        send(place('0, 8, 0, 0, 64), 1, 0, 1, 63);
        idle(3);
        check_out("t6");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
